fibonacci_index: RTL and testbench

Inverse companion to the team's Fibonacci sequence generator. Given a 16-bit value, the block iterates the Fibonacci sequence and returns the smallest index n with F(n) >= value. It also flags whether the value is an exact Fibonacci number. It sits beside the generator on the same start/done handshake, so a testbench or controller can round-trip index -> value -> index.

---
 rtl/fibonacci_index_if.sv | 45 ++++
 rtl/fibonacci_index.sv | 128 ++++++++++++
 tb/tb_fibonacci_index.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fibonacci_index_if.sv
// -----------------------------------------------------------------------------
// fibonacci_index_if
//   Bundles the start/done request and result signals of fibonacci_index.
//
//   Signals:
//     din   [WIDTH-1:0]  query value, sampled only when start is accepted
//     start              request, accepted while the block is IDLE or DONE
//     dout  [IDX_W-1:0]  result index n (smallest n with F(n) >= din)
//     exact              1 when F(n) equals the captured query
//     busy               high while the search is running
//     done               completion indication
//
//   Modports:
//     master : requester side (drives din/start, observes results)
//     slave  : the fibonacci_index block
// -----------------------------------------------------------------------------
interface fibonacci_index_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
);
    logic [WIDTH-1:0] din;
    logic             start;
    logic [IDX_W-1:0] dout;
    logic             exact;
    logic             busy;
    logic             done;

    modport master (
        output din,
        output start,
        input  dout,
        input  exact,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  start,
        output dout,
        output exact,
        output busy,
        output done
    );
endinterface

// File: rtl/fibonacci_index.sv
// -----------------------------------------------------------------------------
// fibonacci_index
//   Returns the smallest index n with F(n) >= din, iterating the Fibonacci
//   sequence F(0)=0, F(1)=1, one step per clock. Also reports whether din is
//   itself a Fibonacci number.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     bus        fibonacci_index_if.slave (din, start, dout, exact, busy, done)
//     state_dbg  current FSM state: 0 = IDLE, 1 = SEARCH, 2 = DONE
//
//   Handshake: start is accepted on a rising edge where start=1 and the block
//   is IDLE or DONE; din is captured on that same edge. start while busy is
//   ignored. done is high in the cycle after the last search edge, and dout /
//   exact are valid from that cycle and hold until the next completion.
//   Latency from the accepting edge to done is n+1 cycles.
//
//   Configuration macro:
//     FIB_INDEX_STICKY_DONE_EN  when defined, DONE is held (done stays high)
//                               until the next accepted start or reset;
//                               otherwise done is a one-cycle pulse.
// -----------------------------------------------------------------------------
module fibonacci_index #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    fibonacci_index_if.slave      bus,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] din_q;
    // One extra bit so F(25) = 75025 fits without wrapping.
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   b;
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] dout_q;
    logic             exact_q;

    logic accept;
    logic found;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign found  = (a >= {1'b0, din_q});

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SEARCH;
            end
            SEARCH: begin
                if (found) state_nxt = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_nxt = SEARCH;
                end else begin
`ifdef FIB_INDEX_STICKY_DONE_EN
                    state_nxt = DONE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode (registered state only, no input-to-output paths)
    always_comb begin
        bus.busy  = (state == SEARCH);
        bus.done  = (state == DONE);
        bus.dout  = dout_q;
        bus.exact = exact_q;
        state_dbg = state;
    end

    // Datapath: sequence registers, captured query and held result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_q   <= '0;
            a       <= '0;
            b       <= '0;
            k       <= '0;
            dout_q  <= '0;
            exact_q <= 1'b0;
        end else begin
            if (accept) begin
                din_q <= bus.din;
                a     <= '0;
                b     <= {{WIDTH{1'b0}}, 1'b1};
                k     <= '0;
            end else if (state == SEARCH) begin
                if (found) begin
                    dout_q  <= k;
                    exact_q <= (a == {1'b0, din_q});
                end else begin
                    a <= b;
                    b <= a + b;
                    k <= k + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fibonacci_index.sv
module tb_fibonacci_index;
    localparam int WIDTH = 16;
    localparam int IDX_W = 5;
    localparam int W     = 12;   // {exact, dout[4:0], latency[5:0]}
    localparam int LIMIT = 40;

    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;

    fibonacci_index_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    fibonacci_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Smallest n with F(n) >= v, computed directly from the definition.
    function automatic void ref_model(input int v, output int n, output bit ex);
        int f0, f1, t;
        f0 = 0;
        f1 = 1;
        n  = 0;
        while (f0 < v) begin
            t  = f0 + f1;
            f0 = f1;
            f1 = t;
            n++;
        end
        ex = (f0 == v);
    endfunction

    function automatic logic [W-1:0] pack_exp(input int v);
        int n;
        bit ex;
        ref_model(v, n, ex);
        return {ex, 5'(n), 6'(n + 1)};
    endfunction

    // ---------------- driver tasks ----------------
    // Present start with value v for one edge; returns #1 after that edge.
    task automatic do_start(input logic [WIDTH-1:0] v);
        @(negedge clk);
        bus.din   = v;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.din   = 16'($urandom_range(0, 65535));
    endtask

    // Counts edges until done is observed; ok=0 on timeout.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pops the expected result and compares against what the DUT shows now.
    task automatic check_result(input string name, input int lat, input bit ok);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, LIMIT);
        end else begin
            if (lat !== int'(e[5:0])) begin
                n_fail++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, e[5:0]);
            end
            n_cmp++;
            if (bus.dout !== e[10:6]) begin
                n_fail++;
                $display("FAIL %s dout: got %0d expected %0d", name, bus.dout, e[10:6]);
            end
            n_cmp++;
            if (bus.exact !== e[11]) begin
                n_fail++;
                $display("FAIL %s exact: got %0b expected %0b", name, bus.exact, e[11]);
            end
        end
    endtask

    task automatic run_query(input string name, input int v);
        int lat;
        bit ok;
        exp_q.push_back(pack_exp(v));
        do_start(16'(v));
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy after accept: got %0b expected 1", name, bus.busy);
        end
        wait_done(lat, ok);
        check_result(name, lat, ok);
`ifndef FIB_INDEX_STICKY_DONE_EN
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done pulse width: got %0b expected 0", name, bus.done);
        end
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.din   = '0;
        #1;
        n_cmp++;
        if ({bus.dout, bus.exact, bus.busy, bus.done, state_dbg} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset outputs: dout=%0d exact=%0b busy=%0b done=%0b state=%0d expected all 0",
                     bus.dout, bus.exact, bus.busy, bus.done, state_dbg);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle after reset: busy=%0b done=%0b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        run_query("din0", 0);
        run_query("din8", 8);
        run_query("din4", 4);
        run_query("din1", 1);
        run_query("din46368", 46368);
        run_query("din65535", 65535);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_query("rand", int'($urandom_range(0, 65535)));
        end
        run_query("rand_small", int'($urandom_range(0, 20)));
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        exp_q.push_back(pack_exp(100));
        do_start(16'd100);
        // Start while searching: must be ignored.
        @(negedge clk);
        bus.din   = 16'd1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, ok);
        check_result("ignore_start", lat + 1, ok);
        // Still in the DONE cycle: this start must be accepted.
        exp_q.push_back(pack_exp(1));
        do_start(16'd1);
        wait_done(lat, ok);
        check_result("back_to_back", lat, ok);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_start(16'd1000);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.dout, bus.exact, bus.busy, bus.done} !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset outputs: dout=%0d exact=%0b busy=%0b done=%0b expected all 0",
                     bus.dout, bus.exact, bus.busy, bus.done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset discard: got busy/done activity expected none");
        end
        run_query("after_reset", 1);
    endtask

`ifdef FIB_INDEX_STICKY_DONE_EN
    task automatic test_sticky_done();
        int lat;
        bit ok;
        bit bad;
        exp_q.push_back(pack_exp(13));
        do_start(16'd13);
        wait_done(lat, ok);
        check_result("sticky13", lat, ok);
        bad = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b1 || bus.dout !== 5'd7 || bus.exact !== 1'b1) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL sticky hold: done=%0b dout=%0d exact=%0b expected 1 7 1",
                     bus.done, bus.dout, bus.exact);
        end
        exp_q.push_back(pack_exp(5));
        do_start(16'd5);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky drop: done=%0b expected 0", bus.done);
        end
        wait_done(lat, ok);
        check_result("sticky5", lat, ok);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef FIB_INDEX_STICKY_DONE_EN
        test_sticky_done();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
